// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, receiver FSM encoding
// and the control strobe bundle passed from receiver FSM to datapath.
package uart_pkg;

    localparam int WORD_SIZE  = 8;
    localparam int OVERSAMPLE = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STARTING  = 2'd1,
        RECEIVING = 2'd2
    } rcvr_state_t;

    typedef struct packed {
        logic clr_sample;
        logic inc_sample;
        logic clr_bit;
        logic shift;
        logic load;
    } rcvr_ctrl_t;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/uart_rcvr_datapath.sv
// Receiver datapath: sample/bit counters, shift and holding registers,
// host handshake flag and the overrun/framing error flags.
module uart_rcvr_datapath
    import uart_pkg::*;
#(
    parameter int word_size  = WORD_SIZE,
    parameter int oversample = OVERSAMPLE
) (
    input  logic                       Clock,
    input  logic                       rst_b,
    input  logic                       Serial_in,
    input  logic                       read_not_ready_in,
    input  rcvr_ctrl_t                 ctrl,
    output logic [$clog2(oversample):0] sample_count,
    output logic [$clog2(word_size):0]  bit_count,
    output logic [word_size-1:0]       RCV_datareg,
    output logic                       read_not_ready_out,
    output logic                       Error1,
    output logic                       Error2
);

    logic [word_size-1:0] RCV_shftreg;

    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            sample_count <= '0;
            bit_count    <= '0;
            RCV_shftreg  <= '0;
        end else begin
            if (ctrl.clr_sample) begin
                sample_count <= '0;
            end else if (ctrl.inc_sample) begin
                sample_count <= sample_count + 1'b1;
            end

            if (ctrl.clr_bit) begin
                bit_count <= '0;
            end else if (ctrl.shift) begin
                bit_count <= bit_count + 1'b1;
            end

            // LSB arrives first, so new bits enter at the top
            if (ctrl.shift) begin
                RCV_shftreg <= {Serial_in, RCV_shftreg[word_size-1:1]};
            end
        end
    end

    // An ack landing on the completion edge retires the old word only
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            RCV_datareg        <= '0;
            read_not_ready_out <= 1'b0;
            Error1             <= 1'b0;
            Error2             <= 1'b0;
        end else if (ctrl.load) begin
            RCV_datareg        <= RCV_shftreg;
            read_not_ready_out <= 1'b1;
            Error2             <= ~Serial_in;
            Error1             <= read_not_ready_out & ~read_not_ready_in;
        end else if (read_not_ready_in) begin
            read_not_ready_out <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rcvr.sv
// UART 8N1 receiver: oversampled start detection and mid-bit sampling
// FSM driving the receiver datapath through control strobes.
module uart_rcvr
    import uart_pkg::*;
#(
    parameter int word_size  = WORD_SIZE,
    parameter int oversample = OVERSAMPLE
) (
    input  logic                 Clock,
    input  logic                 rst_b,
    input  logic                 Sample_tick,
    input  logic                 Serial_in,
    input  logic                 read_not_ready_in,
    output logic [word_size-1:0] RCV_datareg,
    output logic                 read_not_ready_out,
    output logic                 Error1,
    output logic                 Error2
);

    localparam int SCW = cnt_width(oversample);
    localparam int BCW = cnt_width(word_size);

    localparam logic [SCW-1:0] HALF_LAST = SCW'(oversample / 2 - 1);
    localparam logic [SCW-1:0] BIT_LAST  = SCW'(oversample - 1);
    localparam logic [BCW-1:0] WORD_BITS = BCW'(word_size);

    rcvr_state_t     state;
    rcvr_state_t     state_nxt;
    rcvr_ctrl_t      ctrl;
    logic [SCW-1:0]  sample_count;
    logic [BCW-1:0]  bit_count;

    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        if (Sample_tick) begin
            unique case (state)
                IDLE: begin
                    if (!Serial_in) begin
                        state_nxt       = STARTING;
                        ctrl.clr_sample = 1'b1;
                    end
                end
                STARTING: begin
                    // a line back high before mid start bit is a glitch
                    if (Serial_in) begin
                        state_nxt       = IDLE;
                        ctrl.clr_sample = 1'b1;
                    end else if (sample_count == HALF_LAST) begin
                        state_nxt       = RECEIVING;
                        ctrl.clr_sample = 1'b1;
                        ctrl.clr_bit    = 1'b1;
                    end else begin
                        ctrl.inc_sample = 1'b1;
                    end
                end
                RECEIVING: begin
                    if (sample_count != BIT_LAST) begin
                        ctrl.inc_sample = 1'b1;
                    end else begin
                        ctrl.clr_sample = 1'b1;
                        if (bit_count < WORD_BITS) begin
                            ctrl.shift = 1'b1;
                        end else begin
                            ctrl.load = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    uart_rcvr_datapath #(
        .word_size  (word_size),
        .oversample (oversample)
    ) u_datapath (
        .Clock              (Clock),
        .rst_b              (rst_b),
        .Serial_in          (Serial_in),
        .read_not_ready_in  (read_not_ready_in),
        .ctrl               (ctrl),
        .sample_count       (sample_count),
        .bit_count          (bit_count),
        .RCV_datareg        (RCV_datareg),
        .read_not_ready_out (read_not_ready_out),
        .Error1             (Error1),
        .Error2             (Error2)
    );

endmodule

// File: tb/tb_uart_rcvr.sv
// Scoreboard bench for uart_rcvr: frames are driven tick by tick and
// the expected word/flags are queued and checked after each stop sample.
module tb_uart_rcvr;

    logic       Clock = 1'b0;
    logic       rst_b = 1'b0;
    logic       Sample_tick = 1'b0;
    logic       Serial_in = 1'b1;
    logic       Read = 1'b0;
    logic [7:0] RCV_datareg;
    logic       rnr_out;
    logic       Error1;
    logic       Error2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       rnr;
        logic       e1;
        logic       e2;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic       m_pending = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         stop_seen = 1'b0;
    int unsigned div = 0;

    uart_rcvr dut (
        .Clock              (Clock),
        .rst_b              (rst_b),
        .Sample_tick        (Sample_tick),
        .Serial_in          (Serial_in),
        .read_not_ready_in  (Read),
        .RCV_datareg        (RCV_datareg),
        .read_not_ready_out (rnr_out),
        .Error1             (Error1),
        .Error2             (Error2)
    );

    always #5 Clock = ~Clock;

    // one tick every 4th clock, changed on the falling edge
    initial forever begin
        @(negedge Clock);
        div++;
        Sample_tick = (div % 4 == 0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (stop_seen) begin
            stop_seen = 1'b0;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got 0 entries expected 1");
            end else begin
                mon_e = sb.pop_front();
                chk("datareg", {24'd0, RCV_datareg}, {24'd0, mon_e.data});
                chk("rnr_out", {31'd0, rnr_out}, {31'd0, mon_e.rnr});
                chk("error1", {31'd0, Error1}, {31'd0, mon_e.e1});
                chk("error2", {31'd0, Error2}, {31'd0, mon_e.e2});
            end
        end
    end

    // set line for the next tick, optionally strobe read on that tick
    task automatic drive_tick(input logic v, input bit ack);
        @(negedge Clock);
        Serial_in = v;
        #1;
        while (!Sample_tick) begin
            @(negedge Clock);
            #1;
        end
        if (ack) Read = 1'b1;
        @(posedge Clock);
        #1;
        Read = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        repeat (n) drive_tick(1'b1, 1'b0);
    endtask

    task automatic do_read();
        @(negedge Clock);
        #1;
        Read = 1'b1;
        @(posedge Clock);
        #1;
        Read = 1'b0;
        m_pending = 1'b0;
        @(negedge Clock);
        chk("read_ack", {31'd0, rnr_out}, 32'd0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_data"}, {24'd0, RCV_datareg}, 32'd0);
        chk({name, "_rnr"}, {31'd0, rnr_out}, 32'd0);
        chk({name, "_e1"}, {31'd0, Error1}, 32'd0);
        chk({name, "_e2"}, {31'd0, Error2}, 32'd0);
    endtask

    // frame = start, 8 data LSB first, stop; 8 ticks per bit
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input bit ack, input int rst_tick);
        exp_t e;
        logic v;
        int   slot;
        if (rst_tick < 0) begin
            e.data = d;
            e.rnr  = 1'b1;
            e.e1   = m_pending && !ack;
            e.e2   = !stop;
            sb.push_back(e);
            m_pending = 1'b1;
            m_data    = d;
        end
        for (int t = 0; t < 80; t++) begin
            slot = t / 8;
            if (slot == 0) v = 1'b0;
            else if (slot <= 8) v = d[slot-1];
            else v = stop || (t > 76);
            drive_tick(v, ack && (t == 76));
            if (t == 76 && rst_tick < 0) stop_seen = 1'b1;
            if (t == rst_tick) begin
                #2;
                rst_b = 1'b0;
                #1;
                chk_zero("async_rst");
                m_pending = 1'b0;
                m_data    = 8'h00;
                Serial_in = 1'b1;
                repeat (3) @(negedge Clock);
                rst_b = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       rs;
        bit         ra;
        rst_b = 1'b0;
        repeat (3) @(negedge Clock);
        chk_zero("reset");
        rst_b = 1'b1;
        idle_ticks(4);

        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle_ticks(2);
        do_read();

        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle_ticks(2);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        idle_ticks(2);
        send_frame(8'h55, 1'b0, 1'b0, -1);
        idle_ticks(3);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        idle_ticks(2);

        drive_tick(1'b0, 1'b0);
        drive_tick(1'b0, 1'b0);
        idle_ticks(3);
        @(negedge Clock);
        chk("glitch_rnr", {31'd0, rnr_out}, {31'd0, m_pending});
        chk("glitch_data", {24'd0, RCV_datareg}, {24'd0, m_data});
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle_ticks(2);

        send_frame(8'h5A, 1'b1, 1'b0, 46);
        idle_ticks(4);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        idle_ticks(2);
        send_frame(8'hC3, 1'b1, 1'b1, -1);
        idle_ticks(2);

        for (int i = 0; i < 16; i++) begin
            rd = 8'($urandom);
            rs = ($urandom % 4) != 0;
            ra = ($urandom % 3) == 0;
            send_frame(rd, rs, ra, -1);
            idle_ticks($urandom_range(1, 3));
            if ($urandom % 2 == 1) do_read();
        end

        idle_ticks(2);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
